// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//
// Stall/freeze/squash controller for the five-stage MIPS pipeline. Covers the
// hazards forwarding cannot resolve:
//   - load-use
//   - branch/JR operands not yet produced
//   - instruction and data memory wait
//   - taken branch/jump
//   - HALT
//
// Ports
//   CLK, nRST                    clock, asynchronous active-low reset
//   ihit, dhit                   imem fetch returned / dmem access completed
//   dec_instr[31:0]              instruction in decode
//   ex_dest, ex_rfWEN, ex_dREN   EX-stage destination, reg write, load
//   mem_dest, mem_dREN, mem_dWEN MEM-stage destination, load, store
//   br_taken, jmp                decode-stage taken branch / J, JAL, JR
//   mem_halt                     HALT reached MEM
//   pc_en .. memwb_en            latch enables (combinational)
//   ifde_flush, deex_flush       load a NOP bubble into the latch
//   halt                         registered, core halted
//   state_dbg[1:0]               FSM state: 0 RUN, 1 STALL, 2 DWAIT, 3 HALTED
//
// Optional build macro HAZARD_STATS_EN adds two saturating counters:
//   stall_cycles[31:0]  cycles that drove a stall-cycle output
//   flush_count[31:0]   cycles whose ifde_flush came from br_taken | jmp
//
// Handshake: there is no valid/ready pair here. ihit/dhit are single-cycle
// completion strobes; an outstanding dmem access (mem_dREN | mem_dWEN without
// dhit) freezes the whole pipeline until the dhit cycle.
// ---------------------------------------------------------------------------
module hazard_unit #(
  parameter int STALL_W = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [31:0] dec_instr,
  input  logic [4:0]  ex_dest,
  input  logic        ex_rfWEN,
  input  logic        ex_dREN,
  input  logic [4:0]  mem_dest,
  input  logic        mem_dREN,
  input  logic        mem_dWEN,
  input  logic        br_taken,
  input  logic        jmp,
  input  logic        mem_halt,
  output logic        pc_en,
  output logic        ifde_en,
  output logic        deex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifde_flush,
  output logic        deex_flush,
  output logic        halt,
  output logic [1:0]  state_dbg
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    DWAIT  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t             state, nxt_state;
  state_t             saved, nxt_saved;
  state_t             eff;
  logic [STALL_W-1:0] cnt, nxt_cnt;

  // ---------------- decode ----------------
  logic [5:0] op, funct;
  logic [4:0] rs, rt;
  logic       uses_rs, uses_rt, is_br;
  logic       ex_match, mem_match;
  logic [1:0] n_stalls;
  logic       dmem_busy;
  logic       stall_cyc;
  logic       br_flush;
  logic       unused_bits;

  assign op          = dec_instr[31:26];
  assign rs          = dec_instr[25:21];
  assign rt          = dec_instr[20:16];
  assign funct       = dec_instr[5:0];
  assign unused_bits = ^dec_instr[15:6];

  assign uses_rs = !(op == OP_J || op == OP_JAL || op == OP_LUI || op == OP_HALT);
  assign uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  // Instructions that resolve in decode and therefore need their operands now.
  assign is_br   = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_RTYPE && funct == FN_JR);

  assign ex_match  = (ex_dest != 5'd0) &&
                     ((uses_rs && ex_dest == rs) || (uses_rt && ex_dest == rt));
  assign mem_match = (mem_dest != 5'd0) &&
                     ((uses_rs && mem_dest == rs) || (uses_rt && mem_dest == rt));

  always_comb begin
    n_stalls = 2'd0;
    if (is_br && ex_dREN && ex_match)        n_stalls = 2'd2;
    else if (is_br && ex_rfWEN && ex_match)  n_stalls = 2'd1;
    else if (is_br && mem_dREN && mem_match) n_stalls = 2'd1;
    else if (ex_dREN && ex_match)            n_stalls = 2'd1;
  end

  assign dmem_busy = (mem_dREN | mem_dWEN) & ~dhit;

  // ---------------- outputs and next state ----------------
  always_comb begin
    pc_en      = 1'b0;
    ifde_en    = 1'b0;
    deex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifde_flush = 1'b0;
    deex_flush = 1'b0;
    stall_cyc  = 1'b0;
    br_flush   = 1'b0;
    nxt_state  = state;
    nxt_saved  = saved;
    nxt_cnt    = cnt;
    // In the DWAIT release cycle the unit behaves as the state it left.
    eff        = (state == DWAIT) ? saved : state;

    if (!nRST || state == HALTED) begin
      // everything held at 0
    end else if (mem_halt) begin
      memwb_en  = 1'b1;
      nxt_state = HALTED;
    end else if (state == DWAIT && !dhit) begin
      // frozen until dmem completes
    end else if (state != DWAIT && dmem_busy) begin
      nxt_saved = state;
      nxt_state = DWAIT;
    end else begin
      if (state == DWAIT) nxt_state = saved;

      if (eff == STALL) begin
        stall_cyc = 1'b1;
        // cnt only runs in STALL proper, never during the DWAIT release.
        if (state == STALL) begin
          nxt_cnt = (cnt == '0) ? '0 : cnt - STALL_W'(1);
          if (cnt <= STALL_W'(1)) nxt_state = RUN;
        end
      end else if (n_stalls != 2'd0) begin
        stall_cyc = 1'b1;
        if (state == RUN && n_stalls == 2'd2) begin
          nxt_cnt   = STALL_W'(1);
          nxt_state = STALL;
        end
      end else if (ihit) begin
        pc_en      = 1'b1;
        ifde_en    = 1'b1;
        deex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifde_flush = br_taken | jmp;
        br_flush   = br_taken | jmp;
      end else begin
        ifde_en    = 1'b1;
        deex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifde_flush = 1'b1;
      end

      if (stall_cyc) begin
        deex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        deex_flush = 1'b1;
      end
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      saved <= RUN;
      cnt   <= '0;
      halt  <= 1'b0;
    end else begin
      state <= nxt_state;
      saved <= nxt_saved;
      cnt   <= nxt_cnt;
      if (nxt_state == HALTED) halt <= 1'b1;
    end
  end

  assign state_dbg = state;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_cyc && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
      if (br_flush && flush_count != 32'hFFFF_FFFF)   flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  // ---------------- clock / reset / DUT ----------------
  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit;
  logic [31:0] dec_instr;
  logic [4:0]  ex_dest, mem_dest;
  logic        ex_rfWEN, ex_dREN, mem_dREN, mem_dWEN;
  logic        br_taken, jmp, mem_halt;
  logic        pc_en, ifde_en, deex_en, exmem_en, memwb_en;
  logic        ifde_flush, deex_flush, halt;
  logic [1:0]  state_dbg;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  always #5 CLK = ~CLK;

  hazard_unit #(.STALL_W(2)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dec_instr(dec_instr),
    .ex_dest(ex_dest), .ex_rfWEN(ex_rfWEN), .ex_dREN(ex_dREN),
    .mem_dest(mem_dest), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .br_taken(br_taken), .jmp(jmp), .mem_halt(mem_halt),
    .pc_en(pc_en), .ifde_en(ifde_en), .deex_en(deex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifde_flush(ifde_flush), .deex_flush(deex_flush),
    .halt(halt), .state_dbg(state_dbg)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes by name; the bench keeps its own view of where the unit should be.
  localparam int M_RUN = 0, M_STALL = 1, M_DWAIT = 2, M_HALTED = 3;
  // Output vector order: {pc, ifde, deex, exmem, memwb, ifde_flush, deex_flush}
  localparam logic [6:0] O_STALL = 7'b0011101;
  localparam logic [6:0] O_HALT  = 7'b0000100;
  localparam logic [6:0] O_NOFET = 7'b0111110;

  int          m_mode, m_ret, m_bubbles_left;
  logic        m_halt;
  logic [31:0] m_stall_cnt, m_flush_cnt;
  logic        m_was_stall, m_was_brf;

  function automatic int need_stalls();
    logic [5:0] o, f;
    logic [4:0] s, t;
    bit rs_used, rt_used, br, exm, memm;
    o = dec_instr[31:26]; s = dec_instr[25:21]; t = dec_instr[20:16]; f = dec_instr[5:0];
    rs_used = !(o == 6'h02 || o == 6'h03 || o == 6'h0F || o == 6'h3F);
    rt_used = (o == 6'h00 || o == 6'h04 || o == 6'h05 || o == 6'h2B);
    br      = (o == 6'h04 || o == 6'h05 || (o == 6'h00 && f == 6'h08));
    exm     = ex_dest != 0 && ((rs_used && ex_dest == s) || (rt_used && ex_dest == t));
    memm    = mem_dest != 0 && ((rs_used && mem_dest == s) || (rt_used && mem_dest == t));
    if (br && ex_dREN && exm)   return 2;
    if (br && ex_rfWEN && exm)  return 1;
    if (br && mem_dREN && memm) return 1;
    if (ex_dREN && exm)         return 1;
    return 0;
  endfunction

  task automatic model_eval(output logic [6:0] o);
    int acts_as;
    o = 7'b0;
    m_was_stall = 1'b0;
    m_was_brf   = 1'b0;
    if (!nRST) begin
      m_mode = M_RUN; m_ret = M_RUN; m_bubbles_left = 0; m_halt = 1'b0;
      m_stall_cnt = 0; m_flush_cnt = 0;
      return;
    end
    if (m_mode == M_HALTED) return;
    if (mem_halt) begin o = O_HALT; return; end
    if (m_mode == M_DWAIT) begin
      if (!dhit) return;
      acts_as = m_ret;
    end else begin
      if ((mem_dREN || mem_dWEN) && !dhit) return;
      acts_as = m_mode;
    end
    if (acts_as == M_STALL || need_stalls() > 0) begin
      o = O_STALL; m_was_stall = 1'b1;
    end else if (ihit) begin
      o = {5'b11111, br_taken | jmp, 1'b0}; m_was_brf = br_taken | jmp;
    end else begin
      o = O_NOFET;
    end
  endtask

  task automatic model_commit();
    if (!nRST || m_mode == M_HALTED) return;
    if (m_was_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    if (m_was_brf && m_flush_cnt != 32'hFFFF_FFFF)   m_flush_cnt++;
    if (mem_halt) begin m_mode = M_HALTED; m_halt = 1'b1; return; end
    if (m_mode == M_DWAIT) begin
      if (dhit) m_mode = m_ret;
      return;
    end
    if ((mem_dREN || mem_dWEN) && !dhit) begin m_ret = m_mode; m_mode = M_DWAIT; return; end
    if (m_mode == M_STALL) begin
      m_bubbles_left--;
      if (m_bubbles_left <= 0) m_mode = M_RUN;
    end else if (need_stalls() == 2) begin
      m_mode = M_STALL; m_bubbles_left = 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after the falling edge; settle() samples 1 time unit
  // before the rising edge, advance() clocks the model alongside the DUT.
  task automatic settle();
    logic [6:0] e;
    #4;
    model_eval(e);
    exp_q.push_back({25'b0, e});
    check("outs", {25'b0, pc_en, ifde_en, deex_en, exmem_en, memwb_en, ifde_flush, deex_flush},
          exp_q.pop_front());
    check("halt", {31'b0, halt}, {31'b0, m_halt});
    check("state", {30'b0, state_dbg}, m_mode);
`ifdef HAZARD_STATS_EN
    check("stall_cycles", stall_cycles, m_stall_cnt);
    check("flush_count", flush_count, m_flush_cnt);
`endif
  endtask

  task automatic advance();
    @(posedge CLK);
    model_commit();
    @(negedge CLK);
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1; dec_instr = 32'h0;
    ex_dest = 5'd0; ex_rfWEN = 1'b0; ex_dREN = 1'b0;
    mem_dest = 5'd0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    br_taken = 1'b0; jmp = 1'b0; mem_halt = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s,
                                     input logic [4:0] t, input logic [5:0] f);
    return {op, s, t, 10'b0, f};
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd5;
      2:       return 5'd8;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  logic [5:0] op_tab [10] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0F, 6'h23, 6'h2B};
  logic [5:0] fn_tab [3]  = '{6'h21, 6'h08, 6'h2A};

  task automatic random_inputs();
    dec_instr = mk(op_tab[$urandom_range(0, 9)], pick_reg(), pick_reg(), fn_tab[$urandom_range(0, 2)]);
    if ($urandom_range(0, 49) == 0) dec_instr[31:26] = 6'h3F;
    ex_dest   = pick_reg();
    mem_dest  = pick_reg();
    ex_dREN   = ($urandom_range(0, 99) < 30);
    ex_rfWEN  = ex_dREN | ($urandom_range(0, 99) < 50);
    mem_dREN  = ($urandom_range(0, 99) < 25);
    mem_dWEN  = !mem_dREN && ($urandom_range(0, 99) < 10);
    dhit      = ($urandom_range(0, 99) < 65);
    ihit      = ($urandom_range(0, 99) < 80);
    br_taken  = ($urandom_range(0, 99) < 20);
    jmp       = ($urandom_range(0, 99) < 15);
    mem_halt  = ($urandom_range(0, 299) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int halted_for;
    idle();
    nRST = 1'b0;
    m_mode = M_RUN; m_ret = M_RUN; m_bubbles_left = 0; m_halt = 1'b0;
    m_stall_cnt = 0; m_flush_cnt = 0;
    @(negedge CLK);
    settle();
    check("rst_outs", {25'b0, pc_en, ifde_en, deex_en, exmem_en, memwb_en, ifde_flush, deex_flush}, 32'h0);
    advance();
    nRST = 1'b1;
    settle(); advance();

    // load-use: one bubble, then full flow
    ex_dREN = 1'b1; ex_rfWEN = 1'b1; ex_dest = 5'd5; dec_instr = mk(6'h00, 5'd5, 5'd1, 6'h21);
    settle();
    check("lu_stall", {29'b0, pc_en, ifde_en, deex_flush}, 32'b001);
    advance();
    ex_dREN = 1'b0; ex_rfWEN = 1'b0; ex_dest = 5'd0;
    settle();
    check("lu_resume", {29'b0, pc_en, ifde_en, deex_flush}, 32'b110);
    advance();

    // branch after load: two consecutive bubbles through STALL
    ex_dREN = 1'b1; ex_rfWEN = 1'b1; ex_dest = 5'd8; dec_instr = mk(6'h04, 5'd3, 5'd8, 6'h00);
    settle();
    check("bl_stall1", {31'b0, pc_en}, 32'd0);
    advance();
    settle();
    check("bl_state", {30'b0, state_dbg}, 32'd1);
    check("bl_stall2", {31'b0, deex_flush}, 32'd1);
    advance();
    idle();
    dec_instr = mk(6'h04, 5'd3, 5'd8, 6'h00);
    settle();
    check("bl_resume", {31'b0, pc_en}, 32'd1);
    advance();

    // data memory miss for 3 cycles, released by dhit
    idle(); mem_dREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("dm_zero", {25'b0, pc_en, ifde_en, deex_en, exmem_en, memwb_en, ifde_flush, deex_flush}, 32'h0);
      advance();
    end
    dhit = 1'b1;
    settle();
    check("dm_release", {25'b0, pc_en, ifde_en, deex_en, exmem_en, memwb_en, ifde_flush, deex_flush}, 32'h7C);
    advance();

    // destination $0 never stalls
    idle(); ex_dREN = 1'b1; ex_dest = 5'd0; dec_instr = mk(6'h00, 5'd0, 5'd0, 6'h21);
    settle();
    check("r0_nostall", {31'b0, pc_en}, 32'd1);
    advance();

    // taken branch with and without ihit
    idle(); br_taken = 1'b1; dec_instr = mk(6'h04, 5'd1, 5'd2, 6'h00);
    settle();
    check("br_ihit", {30'b0, pc_en, ifde_flush}, 32'b11);
    advance();
    ihit = 1'b0;
    settle();
    check("br_noihit", {30'b0, pc_en, ifde_flush}, 32'b01);
    advance();

    // halt pulse, then reset out of HALTED
    idle(); mem_halt = 1'b1;
    settle(); advance();
    mem_halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("halted_halt", {31'b0, halt}, 32'd1);
      check("halted_en", {25'b0, pc_en, ifde_en, deex_en, exmem_en, memwb_en, ifde_flush, deex_flush}, 32'h0);
      advance();
    end
    nRST = 1'b0;
    settle();
    check("rst_halt", {31'b0, halt}, 32'd0);
    advance();
    nRST = 1'b1;

    // reset in the middle of DWAIT
    idle(); mem_dWEN = 1'b1; dhit = 1'b0;
    settle(); advance();
    settle();
    check("dw_state", {30'b0, state_dbg}, 32'd2);
    advance();
    nRST = 1'b0;
    settle();
    check("dw_rst_state", {30'b0, state_dbg}, 32'd0);
    check("dw_rst_halt", {31'b0, halt}, 32'd0);
    advance();
    nRST = 1'b1; idle();
    settle(); advance();

    // randomized traffic
    halted_for = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      random_inputs();
      halted_for = (m_mode == M_HALTED) ? halted_for + 1 : 0;
      nRST = !(($urandom_range(0, 299) == 0) || halted_for > 4);
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
